decode_operand_stage: RTL

//  ID stage of the CORG pipeline, between fetch and execute, wrapped around register_file.

---
 rtl/corg_pkg.sv | 93 +++++++++
 rtl/decode_operand_stage_if.sv | 47 ++++
 rtl/corg_scoreboard.sv | 38 +++
 rtl/decode_operand_stage.sv | 118 +++++++++++
 4 files changed

// File: rtl/corg_pkg.sv
// Shared constants, instruction field slices and opcode-class decode for the CORG pipeline.
package corg_pkg;

  localparam int unsigned DATA_W     = 16;
  localparam int unsigned REG_ADDR_W = 3;
  localparam int unsigned INSTR_W    = 16;
  localparam int unsigned NUM_REGS   = 1 << REG_ADDR_W;
  localparam int unsigned OPCODE_W   = 4;
  localparam int unsigned IMM_W      = 6;

  localparam logic [OPCODE_W-1:0] OP_R_LAST = 4'h7;
  localparam logic [OPCODE_W-1:0] OP_I_LAST = 4'hB;
  localparam logic [OPCODE_W-1:0] OP_STORE  = 4'hC;
  localparam logic [OPCODE_W-1:0] OP_BRANCH = 4'hD;
  localparam logic [OPCODE_W-1:0] OP_JUMP   = 4'hE;
  localparam logic [OPCODE_W-1:0] OP_NOP    = 4'hF;

  typedef enum logic [2:0] {
    ClsR,
    ClsI,
    ClsStore,
    ClsBranch,
    ClsJump,
    ClsNop
  } op_kind_e;

  typedef struct packed {
    logic uses_rs1;
    logic uses_rs2;
    logic writes_rd;
  } op_class_t;

  // Contents of the ID/EX pipeline register.
  typedef struct packed {
    logic [OPCODE_W-1:0]   opcode;
    logic [REG_ADDR_W-1:0] rd;
    logic                  writes_rd;
    logic [DATA_W-1:0]     op_a;
    logic [DATA_W-1:0]     op_b;
    logic [DATA_W-1:0]     imm;
  } idex_t;

  function automatic logic [OPCODE_W-1:0] instr_op(input logic [INSTR_W-1:0] instr);
    return instr[15:12];
  endfunction

  function automatic logic [REG_ADDR_W-1:0] instr_rd(input logic [INSTR_W-1:0] instr);
    return instr[11:9];
  endfunction

  function automatic logic [REG_ADDR_W-1:0] instr_rs1(input logic [INSTR_W-1:0] instr);
    return instr[8:6];
  endfunction

  function automatic logic [REG_ADDR_W-1:0] instr_rs2(input logic [INSTR_W-1:0] instr);
    return instr[5:3];
  endfunction

  function automatic logic [DATA_W-1:0] instr_imm(input logic [INSTR_W-1:0] instr);
    return {{(DATA_W - IMM_W){instr[5]}}, instr[5:0]};
  endfunction

  function automatic op_kind_e op_kind(input logic [OPCODE_W-1:0] op);
    if (op <= OP_R_LAST) begin
      return ClsR;
    end else if (op <= OP_I_LAST) begin
      return ClsI;
    end else if (op == OP_STORE) begin
      return ClsStore;
    end else if (op == OP_BRANCH) begin
      return ClsBranch;
    end else if (op == OP_JUMP) begin
      return ClsJump;
    end
    return ClsNop;
  endfunction

  function automatic op_class_t decode_class(input logic [OPCODE_W-1:0] op);
    op_class_t cls;
    cls = '0;
    unique case (op_kind(op))
      ClsR:      cls = '{uses_rs1: 1'b1, uses_rs2: 1'b1, writes_rd: 1'b1};
      ClsI:      cls = '{uses_rs1: 1'b1, uses_rs2: 1'b0, writes_rd: 1'b1};
      ClsStore:  cls = '{uses_rs1: 1'b1, uses_rs2: 1'b1, writes_rd: 1'b0};
      ClsBranch: cls = '{uses_rs1: 1'b1, uses_rs2: 1'b1, writes_rd: 1'b0};
      ClsJump:   cls = '0;
      ClsNop:    cls = '0;
      default:   cls = '0;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/decode_operand_stage_if.sv
// Fetch-to-ID handshake plus the ID/EX register outputs towards execute.
// master: the decode stage; slave: the surrounding fetch/execute logic.
interface decode_operand_stage_if;
  import corg_pkg::*;

  logic                  in_valid;
  logic                  in_ready;
  logic [INSTR_W-1:0]    in_instr;

  logic                  out_valid;
  logic                  out_ready;
  logic [OPCODE_W-1:0]   out_opcode;
  logic [REG_ADDR_W-1:0] out_rd;
  logic                  out_writes_rd;
  logic [DATA_W-1:0]     out_op_a;
  logic [DATA_W-1:0]     out_op_b;
  logic [DATA_W-1:0]     out_imm;

  modport master (
    input  in_valid,
    output in_ready,
    input  in_instr,
    output out_valid,
    input  out_ready,
    output out_opcode,
    output out_rd,
    output out_writes_rd,
    output out_op_a,
    output out_op_b,
    output out_imm
  );

  modport slave (
    output in_valid,
    input  in_ready,
    output in_instr,
    input  out_valid,
    output out_ready,
    input  out_opcode,
    input  out_rd,
    input  out_writes_rd,
    input  out_op_a,
    input  out_op_b,
    input  out_imm
  );

endinterface

// File: rtl/corg_scoreboard.sv
// Per-register pending-write vector. A set and a clear of the same register on one edge
// leaves it pending, since the new writer is younger than the retiring one.
module corg_scoreboard
  import corg_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  set_en,
  input  logic [REG_ADDR_W-1:0] set_idx,
  input  logic                  clr_en,
  input  logic [REG_ADDR_W-1:0] clr_idx,
  output logic [NUM_REGS-1:0]   pending
);

  logic [NUM_REGS-1:0] pending_q;
  logic [NUM_REGS-1:0] pending_d;

  always_comb begin
    pending_d = pending_q;
    if (clr_en) begin
      pending_d[clr_idx] = 1'b0;
    end
    if (set_en) begin
      pending_d[set_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  assign pending = pending_q;

endmodule

// File: rtl/decode_operand_stage.sv
// CORG ID stage: decodes the instruction, reads operands, stalls on RAW hazards and fills ID/EX.
// Optional build macro DECODE_FORWARDING_EN bypasses same-cycle writeback data into operands.
module decode_operand_stage
  import corg_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst,
  decode_operand_stage_if.master        bus,
  output logic [REG_ADDR_W-1:0]         rf_read_address_1,
  output logic [REG_ADDR_W-1:0]         rf_read_address_2,
  input  logic [DATA_W-1:0]             rf_read_data_1,
  input  logic [DATA_W-1:0]             rf_read_data_2,
  input  logic                          wb_en,
  input  logic [REG_ADDR_W-1:0]         wb_dest,
  input  logic [DATA_W-1:0]             wb_data,
  input  logic                          flush,
  output logic                          hazard_stall
);

  logic [OPCODE_W-1:0]   op;
  logic [REG_ADDR_W-1:0] rs1;
  logic [REG_ADDR_W-1:0] rs2;
  op_class_t             cls;

  logic [NUM_REGS-1:0]   pending;
  logic                  fwd_1;
  logic                  fwd_2;
  logic                  idex_hit_1;
  logic                  idex_hit_2;
  logic                  haz_1;
  logic                  haz_2;
  logic                  hazard;
  logic                  in_ready;
  logic                  accept;
  logic                  out_fire;

  logic                  valid_q;
  logic                  valid_d;
  idex_t                 idex_q;
  idex_t                 idex_d;

  assign op  = instr_op(bus.in_instr);
  assign rs1 = instr_rs1(bus.in_instr);
  assign rs2 = instr_rs2(bus.in_instr);
  assign cls = decode_class(op);

  assign rf_read_address_1 = rs1;
  assign rf_read_address_2 = rs2;

`ifdef DECODE_FORWARDING_EN
  assign fwd_1 = wb_en && (wb_dest == rs1) && pending[rs1];
  assign fwd_2 = wb_en && (wb_dest == rs2) && pending[rs2];
`else
  assign fwd_1 = 1'b0;
  assign fwd_2 = 1'b0;
`endif

  // The instruction sitting in ID/EX has not yet set its scoreboard bit.
  assign idex_hit_1 = valid_q && idex_q.writes_rd && (idex_q.rd == rs1);
  assign idex_hit_2 = valid_q && idex_q.writes_rd && (idex_q.rd == rs2);

  assign haz_1  = cls.uses_rs1 && ((pending[rs1] && !fwd_1) || idex_hit_1);
  assign haz_2  = cls.uses_rs2 && ((pending[rs2] && !fwd_2) || idex_hit_2);
  assign hazard = haz_1 || haz_2;

  assign in_ready     = !rst && !flush && !hazard && (!valid_q || bus.out_ready);
  assign accept       = bus.in_valid && in_ready;
  assign out_fire     = valid_q && bus.out_ready;
  assign hazard_stall = !rst && bus.in_valid && hazard;

  always_comb begin
    idex_d  = idex_q;
    valid_d = valid_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d          = 1'b1;
      idex_d.opcode    = op;
      idex_d.rd        = instr_rd(bus.in_instr);
      idex_d.writes_rd = cls.writes_rd;
      idex_d.op_a      = fwd_1 ? wb_data : rf_read_data_1;
      idex_d.op_b      = fwd_2 ? wb_data : rf_read_data_2;
      idex_d.imm       = instr_imm(bus.in_instr);
    end else if (out_fire) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      idex_q  <= '0;
    end else begin
      valid_q <= valid_d;
      idex_q  <= idex_d;
    end
  end

  corg_scoreboard u_scoreboard (
    .clk     (clk),
    .rst     (rst),
    .set_en  (out_fire && idex_q.writes_rd),
    .set_idx (idex_q.rd),
    .clr_en  (wb_en),
    .clr_idx (wb_dest),
    .pending (pending)
  );

  assign bus.in_ready      = in_ready;
  assign bus.out_valid     = valid_q;
  assign bus.out_opcode    = idex_q.opcode;
  assign bus.out_rd        = idex_q.rd;
  assign bus.out_writes_rd = idex_q.writes_rd;
  assign bus.out_op_a      = idex_q.op_a;
  assign bus.out_op_b      = idex_q.op_b;
  assign bus.out_imm       = idex_q.imm;

endmodule
